// File: rtl/mem_resp_pkg.sv
// -----------------------------------------------------------------------------
// mem_resp_pkg
// Shared definitions for the memory responder slice.
//   state_e      : responder FSM state encoding
//   CNT_W        : width of the wait-state counter (LATENCY range 0..15)
//   ALIGN_MASK   : byte-address bits that must be zero for a word access
//   is_misaligned: helper that applies ALIGN_MASK to the low address bits
// -----------------------------------------------------------------------------
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    localparam int CNT_W = 4;

    localparam logic [1:0] ALIGN_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return (addr_lsbs & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Request/response bundle between the core's memory port (master) and the
// memory responder (slave).
//   req_valid/req_ready : request handshake, accepted on valid & ready
//   req_we              : 1 = write, 0 = read
//   req_addr            : byte address
//   req_wdata           : write data
//   rsp_valid           : one-cycle response strobe
//   rsp_rdata           : read data (0 for writes and errors)
//   rsp_err             : misaligned or out-of-range request
//   busy                : responder is not idle
// -----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int WIDTH = 32
) ();

    logic             req_valid;
    logic             req_we;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             req_ready;
    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_rdata;
    logic             rsp_err;
    logic             busy;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err,
        input  busy
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err,
        output busy
    );

endinterface

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Single-port synchronous RAM, registered read, read-before-write, no reset.
//   clk   : clock
//   en    : access enable; rdata only updates on enabled edges
//   we    : write enable (qualified by en)
//   idx   : word index
//   wdata : write data
//   rdata : registered read data (old contents on a write access)
// -----------------------------------------------------------------------------
module mem_array #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem[idx];
            if (we) begin
                mem[idx] <= wdata;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder for the multicycle core's unified memory port.
// Accepts one word request at a time, waits LATENCY cycles, then presents a
// one-cycle response with registered read data and error flag.
//   clk : clock, rising edge
//   rst : asynchronous, active-low reset
//   bus : mem_responder_if.slave (request handshake, response, busy)
// Parameters: WIDTH (data/address bits), DEPTH (words), LATENCY (0..15).
// -----------------------------------------------------------------------------
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] CNT_INIT =
        (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    localparam logic [WIDTH-1:0] DEPTH_W = WIDTH'(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               err_q, err_d;
    logic               rsp_err_q, rsp_err_d;
    logic               rd_ok_q, rd_ok_d;

    logic               accept;
    logic               go_resp;
    logic [WIDTH-1:0]   req_word;
    logic               req_err;
    logic               op_we;
    logic [IDX_W-1:0]   op_idx;
    logic [WIDTH-1:0]   op_wdata;
    logic               op_err;
    logic               ram_en;
    logic [WIDTH-1:0]   ram_rdata;

    // Error decode on the live request; only meaningful at acceptance.
    assign req_word = {2'b00, bus.req_addr[WIDTH-1:2]};
    assign req_err  = is_misaligned(bus.req_addr[1:0]) | (req_word >= DEPTH_W);

    assign accept = (state_q == ST_IDLE) & bus.req_valid;

    // With LATENCY=0 the RAM access happens on the accept edge itself, so the
    // operation must come straight from the bus; otherwise from the latches.
    always_comb begin
        if (state_q == ST_IDLE) begin
            op_we    = bus.req_we;
            op_idx   = bus.req_addr[IDX_W+1:2];
            op_wdata = bus.req_wdata;
            op_err   = req_err;
        end else begin
            op_we    = we_q;
            op_idx   = idx_q;
            op_wdata = wdata_q;
            op_err   = err_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rsp_err_d = rsp_err_q;
        rd_ok_d   = rd_ok_q;
        go_resp   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    idx_d   = bus.req_addr[IDX_W+1:2];
                    wdata_d = bus.req_wdata;
                    err_d   = req_err;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        go_resp = 1'b1;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    go_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response registers update only on the edge entering RESP.
        if (go_resp) begin
            rsp_err_d = op_err;
            rd_ok_d   = ~op_we & ~op_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rsp_err_q <= 1'b0;
            rd_ok_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            idx_q     <= idx_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            rsp_err_q <= rsp_err_d;
            rd_ok_q   <= rd_ok_d;
        end
    end

    // The RAM has no reset, so gate its enable while reset is held to make
    // sure no pending or newly presented write can land during reset.
    assign ram_en = go_resp & ~op_err & rst;

    mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (op_we),
        .idx   (op_idx),
        .wdata (op_wdata),
        .rdata (ram_rdata)
    );

    // RAM rdata only changes on RESP entry, so it already holds between
    // responses; rd_ok_q masks it to zero for writes, errors and after reset.
    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    mem_responder_if #(.WIDTH(32)) if0 ();
    mem_responder_if #(.WIDTH(32)) if2 ();
    mem_responder_if #(.WIDTH(32)) if15 ();

    mem_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(0))  u_l0  (.clk(clk), .rst(rst), .bus(if0.slave));
    mem_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(2))  u_l2  (.clk(clk), .rst(rst), .bus(if2.slave));
    mem_responder #(.WIDTH(32), .DEPTH(256), .LATENCY(15)) u_l15 (.clk(clk), .rst(rst), .bus(if15.slave));

    task automatic set_req(input int sel, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
        case (sel)
            0:  begin if0.req_valid = v;  if0.req_we = we;  if0.req_addr = addr;  if0.req_wdata = wdata;  end
            2:  begin if2.req_valid = v;  if2.req_we = we;  if2.req_addr = addr;  if2.req_wdata = wdata;  end
            default: begin if15.req_valid = v; if15.req_we = we; if15.req_addr = addr; if15.req_wdata = wdata; end
        endcase
    endtask

    function automatic logic get_ready(input int sel);
        case (sel) 0: return if0.req_ready; 2: return if2.req_ready; default: return if15.req_ready; endcase
    endfunction
    function automatic logic get_valid(input int sel);
        case (sel) 0: return if0.rsp_valid; 2: return if2.rsp_valid; default: return if15.rsp_valid; endcase
    endfunction
    function automatic logic get_busy(input int sel);
        case (sel) 0: return if0.busy; 2: return if2.busy; default: return if15.busy; endcase
    endfunction
    function automatic logic get_err(input int sel);
        case (sel) 0: return if0.rsp_err; 2: return if2.rsp_err; default: return if15.rsp_err; endcase
    endfunction
    function automatic logic [31:0] get_rdata(input int sel);
        case (sel) 0: return if0.rsp_rdata; 2: return if2.rsp_rdata; default: return if15.rsp_rdata; endcase
    endfunction

    // One request from an idle sample point (1 ns after an edge). lat is the
    // number of edges after the accept edge until rsp_valid is seen.
    task automatic xact(input int sel, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat,
                        output logic [31:0] rdata, output logic err,
                        output int busy_cnt, output logic busy_after);
        set_req(sel, 1'b1, we, addr, wdata);
        @(posedge clk); #1;
        set_req(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        lat = 0;
        busy_cnt = 0;
        rdata = 32'hx;
        err = 1'bx;
        while (!get_valid(sel) && lat < 40) begin
            if (get_busy(sel)) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (get_valid(sel)) begin
            if (get_busy(sel)) busy_cnt++;
            rdata = get_rdata(sel);
            err = get_err(sel);
        end
        @(posedge clk); #1;
        busy_after = get_busy(sel);
        $display("xact L%0d %s addr=%08h wdata=%08h -> lat=%0d rdata=%08h err=%0b busy_cycles=%0d",
                 sel, we ? "WR" : "RD", addr, wdata, lat, rdata, err, busy_cnt);
    endtask

    task automatic test_reset();
        set_req(0, 0, 0, 0, 0);
        set_req(2, 0, 0, 0, 0);
        set_req(15, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (if2.req_ready !== 1'b1) $display("FAIL reset_ready got=%0b exp=1", if2.req_ready); else n_pass++;
        n_checks++; if (if2.rsp_valid !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", if2.rsp_valid); else n_pass++;
        n_checks++; if (if2.rsp_err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", if2.rsp_err); else n_pass++;
        n_checks++; if (if2.rsp_rdata !== 32'h0) $display("FAIL reset_rdata got=%08h exp=0", if2.rsp_rdata); else n_pass++;
        n_checks++; if (if2.busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", if2.busy); else n_pass++;
        n_checks++; if (if15.req_ready !== 1'b1 || if0.req_ready !== 1'b1) $display("FAIL reset_ready_others got=%0b/%0b exp=1/1", if0.req_ready, if15.req_ready); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read_l2();
        int lat, bc; logic [31:0] rd; logic er, ba;
        xact(2, 1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er, bc, ba);
        n_checks++; if (lat !== 2) $display("FAIL l2_wr_latency got=%0d exp=2", lat); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL l2_wr_err got=%0b exp=0", er); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL l2_wr_rdata got=%08h exp=0", rd); else n_pass++;
        n_checks++; if (bc !== 3) $display("FAIL l2_wr_busy_cycles got=%0d exp=3", bc); else n_pass++;
        n_checks++; if (ba !== 1'b0) $display("FAIL l2_wr_busy_after got=%0b exp=0", ba); else n_pass++;
        xact(2, 1'b0, 32'h10, 32'h0, lat, rd, er, bc, ba);
        n_checks++; if (lat !== 2) $display("FAIL l2_rd_latency got=%0d exp=2", lat); else n_pass++;
        n_checks++; if (rd !== 32'hDEADBEEF) $display("FAIL l2_rd_rdata got=%08h exp=deadbeef", rd); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL l2_rd_err got=%0b exp=0", er); else n_pass++;
        // rsp_rdata holds after the strobe
        n_checks++; if (if2.rsp_rdata !== 32'hDEADBEEF) $display("FAIL l2_rdata_hold got=%08h exp=deadbeef", if2.rsp_rdata); else n_pass++;
    endtask

    task automatic test_errors();
        int lat, bc; logic [31:0] rd; logic er, ba;
        xact(2, 1'b1, 32'h13, 32'hAAAA5555, lat, rd, er, bc, ba);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_misaligned got err=%0b rdata=%08h exp err=1 rdata=0", er, rd); else n_pass++;
        xact(2, 1'b1, 32'h400, 32'h5555AAAA, lat, rd, er, bc, ba);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_range got err=%0b rdata=%08h exp err=1 rdata=0", er, rd); else n_pass++;
        n_checks++; if (lat !== 2) $display("FAIL err_latency got=%0d exp=2", lat); else n_pass++;
        xact(2, 1'b0, 32'h11, 32'h0, lat, rd, er, bc, ba);
        n_checks++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL err_rd_misaligned got err=%0b rdata=%08h exp err=1 rdata=0", er, rd); else n_pass++;
        // last in-range word
        xact(2, 1'b1, 32'h3FC, 32'h600DF00D, lat, rd, er, bc, ba);
        xact(2, 1'b0, 32'h3FC, 32'h0, lat, rd, er, bc, ba);
        n_checks++; if (er !== 1'b0 || rd !== 32'h600DF00D) $display("FAIL top_word got err=%0b rdata=%08h exp err=0 rdata=600df00d", er, rd); else n_pass++;
        xact(2, 1'b0, 32'h10, 32'h0, lat, rd, er, bc, ba);
        n_checks++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) $display("FAIL err_no_corrupt got err=%0b rdata=%08h exp err=0 rdata=deadbeef", er, rd); else n_pass++;
    endtask

    task automatic test_hold_change();
        int lat, bc; logic [31:0] rd; logic er, ba;
        xact(2, 1'b1, 32'h20, 32'h11111111, lat, rd, er, bc, ba);
        xact(2, 1'b1, 32'h24, 32'h22222222, lat, rd, er, bc, ba);
        set_req(2, 1'b1, 1'b0, 32'h20, 32'h0);
        @(posedge clk); #1;
        n_checks++; if (if2.req_ready !== 1'b0) $display("FAIL hold_ready_k0 got=%0b exp=0", if2.req_ready); else n_pass++;
        set_req(2, 1'b1, 1'b1, 32'h24, 32'hFFFFFFFF);
        @(posedge clk); #1;
        n_checks++; if (if2.req_ready !== 1'b0) $display("FAIL hold_ready_k1 got=%0b exp=0", if2.req_ready); else n_pass++;
        set_req(2, 1'b1, 1'b1, 32'h28, 32'hFFFFFFFF);
        @(posedge clk); #1;
        n_checks++; if (if2.rsp_valid !== 1'b1 || if2.rsp_rdata !== 32'h11111111) $display("FAIL hold_resp got valid=%0b rdata=%08h exp valid=1 rdata=11111111", if2.rsp_valid, if2.rsp_rdata); else n_pass++;
        n_checks++; if (if2.req_ready !== 1'b0) $display("FAIL hold_ready_resp got=%0b exp=0", if2.req_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (if2.req_ready !== 1'b1 || if2.rsp_valid !== 1'b0) $display("FAIL hold_idle got ready=%0b valid=%0b exp ready=1 valid=0", if2.req_ready, if2.rsp_valid); else n_pass++;
        set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("xact L2 RD addr=00000020 held, bus changed during WAIT");
        xact(2, 1'b0, 32'h24, 32'h0, lat, rd, er, bc, ba);
        n_checks++; if (rd !== 32'h22222222) $display("FAIL hold_no_stray_write got=%08h exp=22222222", rd); else n_pass++;
    endtask

    task automatic test_latency0();
        int lat, bc; logic [31:0] rd; logic er, ba;
        xact(0, 1'b1, 32'h10, 32'hCAFEF00D, lat, rd, er, bc, ba);
        n_checks++; if (lat !== 0) $display("FAIL l0_wr_latency got=%0d exp=0", lat); else n_pass++;
        n_checks++; if (bc !== 1) $display("FAIL l0_busy_cycles got=%0d exp=1", bc); else n_pass++;
        // hold valid: accepts at t0 and t0+2, never t0+1
        set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
        @(posedge clk); #1;
        n_checks++; if (if0.rsp_valid !== 1'b1 || if0.rsp_rdata !== 32'hCAFEF00D) $display("FAIL l0_rd got valid=%0b rdata=%08h exp valid=1 rdata=cafef00d", if0.rsp_valid, if0.rsp_rdata); else n_pass++;
        n_checks++; if (if0.req_ready !== 1'b0) $display("FAIL l0_ready_resp got=%0b exp=0", if0.req_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (if0.rsp_valid !== 1'b0 || if0.req_ready !== 1'b1 || if0.busy !== 1'b0) $display("FAIL l0_gap got valid=%0b ready=%0b busy=%0b exp 0/1/0", if0.rsp_valid, if0.req_ready, if0.busy); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (if0.rsp_valid !== 1'b1) $display("FAIL l0_second_accept got=%0b exp=1", if0.rsp_valid); else n_pass++;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("xact L0 RD addr=00000010 held, back-to-back");
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait();
        int lat, bc; logic [31:0] rd; logic er, ba;
        xact(2, 1'b1, 32'h20, 32'h0, lat, rd, er, bc, ba);
        xact(2, 1'b0, 32'h10, 32'h0, lat, rd, er, bc, ba);
        set_req(2, 1'b1, 1'b1, 32'h20, 32'h12345678);
        @(posedge clk); #1;
        set_req(2, 1'b0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (if2.busy !== 1'b1) $display("FAIL rstw_in_wait got busy=%0b exp=1", if2.busy); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (if2.busy !== 1'b0 || if2.req_ready !== 1'b1 || if2.rsp_valid !== 1'b0) $display("FAIL rstw_ctrl got busy=%0b ready=%0b valid=%0b exp 0/1/0", if2.busy, if2.req_ready, if2.rsp_valid); else n_pass++;
        n_checks++; if (if2.rsp_rdata !== 32'h0 || if2.rsp_err !== 1'b0) $display("FAIL rstw_data got rdata=%08h err=%0b exp 0/0", if2.rsp_rdata, if2.rsp_err); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        $display("xact L2 WR addr=00000020 wdata=12345678 aborted by reset");
        @(posedge clk); #1;
        xact(2, 1'b0, 32'h20, 32'h0, lat, rd, er, bc, ba);
        n_checks++; if (rd !== 32'h0) $display("FAIL rstw_dropped got=%08h exp=0", rd); else n_pass++;
    endtask

    task automatic test_back_to_back_l15();
        int lat, bc; logic [31:0] rd; logic er, ba;
        int na, e1, e2, busy_cnt;
        logic prev_ready;
        logic [31:0] rd_b2b;
        xact(15, 1'b1, 32'h10, 32'h0BADF00D, lat, rd, er, bc, ba);
        n_checks++; if (lat !== 15) $display("FAIL l15_latency got=%0d exp=15", lat); else n_pass++;
        n_checks++; if (bc !== 16) $display("FAIL l15_busy_cycles got=%0d exp=16", bc); else n_pass++;
        na = 0; e1 = 0; e2 = 0; busy_cnt = 0; rd_b2b = 32'h0;
        set_req(15, 1'b1, 1'b0, 32'h10, 32'h0);
        prev_ready = get_ready(15);
        for (int e = 1; e <= 60 && na < 2; e++) begin
            @(posedge clk); #1;
            if (prev_ready) begin
                na++;
                if (na == 1) e1 = e; else e2 = e;
            end
            if (na == 1 && get_busy(15)) busy_cnt++;
            if (na == 1 && get_valid(15)) rd_b2b = get_rdata(15);
            prev_ready = get_ready(15);
        end
        set_req(15, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("xact L15 RD addr=00000010 held: accepts at %0d and %0d", e1, e2);
        n_checks++; if (na !== 2) $display("FAIL b2b_accepts got=%0d exp=2", na); else n_pass++;
        n_checks++; if (e2 - e1 !== 17) $display("FAIL b2b_spacing got=%0d exp=17", e2 - e1); else n_pass++;
        n_checks++; if (busy_cnt !== 16) $display("FAIL b2b_busy got=%0d exp=16", busy_cnt); else n_pass++;
        n_checks++; if (rd_b2b !== 32'h0BADF00D) $display("FAIL b2b_rdata got=%08h exp=0badf00d", rd_b2b); else n_pass++;
        repeat (20) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_write_read_l2();
        test_errors();
        test_hold_change();
        test_latency0();
        test_reset_in_wait();
        test_back_to_back_l15();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle MIPS core's unified instruction/data memory port. Accepts one word read or write request at a time from the datapath/control side, inserts a programmable number of wait states, and returns a single-cycle response with read data and an error flag. The control FSM stalls on `busy` instead of treating memory as combinational, which makes slower on-chip or off-chip memories usable.

## Interface
- `WIDTH`, 32: data and address width in bits.
- `DEPTH`, 256: number of WIDTH-bit words in the array.
- `LATENCY`, 2: wait-state count, range 0..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present; held by the requester until accepted.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  WIDTH  byte address; word index = `req_addr[WIDTH-1:2]`.
- `req_wdata`  in  WIDTH  write data.
- `req_ready`  out  1  responder can accept; a request is accepted on an edge where `req_valid & req_ready`.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  WIDTH  read data; 0 for writes and errors.
- `rsp_err`  out  1  request misaligned or out of range; valid with `rsp_valid`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On acceptance, latch `we`, `addr`, and `wdata`, and compute `err` = (`addr[1:0]`≠0) | (word index ≥ DEPTH).
  - If LATENCY=0, go to RESP.
  - Otherwise load `cnt`=LATENCY-1 and go to WAIT.
- WAIT: if `cnt`=0, go to RESP; otherwise decrement `cnt`.
- Transition into RESP (the same edge):
  - Write, no error: `array[idx]` ← `wdata`.
  - Read, no error: `rsp_rdata` ← `array[idx]`.
  - Error: no array access and `rsp_rdata` ← 0.
  - `rsp_err` ← `err`.
- RESP: `rsp_valid`=1 for exactly one cycle, then unconditionally go to IDLE.
- `req_ready`=0 in WAIT and RESP. `req_valid` in those states is ignored; the requester keeps holding it.
- Changes on `req_*` after acceptance have no effect on the response.
- Reset (asynchronous, any state):
  - State returns to IDLE and `cnt`=0.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `busy`=0, `req_ready`=1.
  - A pending write that has not reached RESP is dropped.
  - Array contents are not cleared and are undefined after power-up.

## Timing
- Acceptance edge t0. RESP is entered on edge t0+LATENCY, so `rsp_valid` is high during the cycle after edge t0+LATENCY.
  - LATENCY=0: response in the cycle right after the accept cycle.
- `busy` rises on t0 and falls on the edge leaving RESP, t0+LATENCY+1.
- Earliest next acceptance is edge t0+LATENCY+2. Minimum request spacing is LATENCY+2 cycles.
- `rsp_rdata` and `rsp_err` are registered and hold their values until the next RESP entry or reset.
- Write-then-read to the same address returns the new data (the write completes before the read is accepted).

## Structure
- Shared package `mem_resp_pkg`:
  - State encoding: IDLE=2'b00, WAIT=2'b01, RESP=2'b10.
  - `CNT_W`=4.
  - Alignment mask constant.
- Sub-module `mem_array`: single-port synchronous RAM with parameters WIDTH and DEPTH, and ports `clk`, `en`, `we`, `idx`, `wdata`, `rdata`.
  - Registered read, read-before-write.
  - No reset.
- `mem_responder` holds the FSM, the counter, request latches, and error decode.

## Test plan
- LATENCY=2, write 0xDEADBEEF to 0x10 accepted at t0 → `busy` high, `rsp_valid`=1 in the cycle after t0+2, `rsp_err`=0, `rsp_rdata`=0. Then read 0x10 → `rsp_rdata`=0xDEADBEEF.
- LATENCY=0, read 0x10 → `rsp_valid` in the cycle right after acceptance. Next acceptance no earlier than t0+2.
- Write to 0x13 (misaligned) and to 0x400 (DEPTH=256) → `rsp_err`=1, `rsp_rdata`=0. A following read of 0x10 still returns 0xDEADBEEF.
- `req_valid` held high continuously with changing addresses during WAIT → only the latched address is served, and `req_ready`=0 until RESP has passed.
- Reset asserted in WAIT of a write of 0x12345678 to 0x20 → all outputs return to reset values immediately. A later read of 0x20 does not return 0x12345678 (if pre-written to 0 before the write, it must return 0).
- LATENCY=15, back-to-back reads → request spacing is exactly 17 cycles, and `busy` is high for exactly 16 cycles per request.
